// File: rtl/mem_access_unit.sv
// M-stage load/store bus master: IDLE -> REQ -> DONE, minimum 3 cycles, stall_o holds the pipeline until DONE.
// Optional misalignment trap enabled by `define MEM_ALIGN_CHECK_EN (default build: no alignment check).
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  load_type_i,
  input  logic [2:0]  store_type_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        stall_o,
  output logic [31:0] load_data_o,
  output logic        load_valid_o,
  output logic        bus_err_o,
  output logic        addr_exc_o
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t        state;
  logic [CW-1:0] tcnt;
  logic [2:0]    ld_type;
  logic [1:0]    addr_lo;

  logic          access;
  logic          misaligned;
  logic [3:0]    st_be;
  logic [31:0]   st_wdata;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   ld_ext;

  assign access  = mem_read_i | mem_write_i;
  assign stall_o = (state == REQ) | ((state == IDLE) & access);

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = wdata_i;
    case (store_type_i)
      3'd1: begin
        st_be    = 4'b0001 << addr_i[1:0];
        st_wdata = {4{wdata_i[7:0]}};
      end
      3'd2: begin
        st_be    = addr_i[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane selection uses the byte offset captured at issue, not the live address.
  always_comb begin
    rd_byte = bus_rdata_i[7:0];
    case (addr_lo)
      2'd1:    rd_byte = bus_rdata_i[15:8];
      2'd2:    rd_byte = bus_rdata_i[23:16];
      2'd3:    rd_byte = bus_rdata_i[31:24];
      default: ;
    endcase
    rd_half = addr_lo[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    case (ld_type)
      3'd1:    ld_ext = {{24{rd_byte[7]}}, rd_byte};
      3'd2:    ld_ext = {24'h0, rd_byte};
      3'd3:    ld_ext = {{16{rd_half[15]}}, rd_half};
      3'd4:    ld_ext = {16'h0, rd_half};
      default: ld_ext = bus_rdata_i;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic word_acc;
  logic half_acc;

  // A simultaneous read+write is a write, so the store type decides the width.
  always_comb begin
    if (mem_write_i) begin
      half_acc = (store_type_i == 3'd2);
      word_acc = (store_type_i != 3'd1) && (store_type_i != 3'd2);
    end else begin
      half_acc = (load_type_i == 3'd3) || (load_type_i == 3'd4);
      word_acc = (load_type_i == 3'd0) || (load_type_i > 3'd4);
    end
    misaligned = access & ((word_acc & (addr_i[1:0] != 2'b00)) | (half_acc & addr_i[0]));
  end
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      tcnt         <= '0;
      ld_type      <= 3'd0;
      addr_lo      <= 2'd0;
      bus_req_o    <= 1'b0;
      bus_we_o     <= 1'b0;
      bus_addr_o   <= 32'h0;
      bus_be_o     <= 4'h0;
      bus_wdata_o  <= 32'h0;
      load_data_o  <= 32'h0;
      load_valid_o <= 1'b0;
      bus_err_o    <= 1'b0;
      addr_exc_o   <= 1'b0;
    end else begin
      load_valid_o <= 1'b0;
      bus_err_o    <= 1'b0;
      addr_exc_o   <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            bus_addr_o  <= {addr_i[31:2], 2'b00};
            addr_lo     <= addr_i[1:0];
            ld_type     <= load_type_i;
            bus_we_o    <= mem_write_i;
            bus_be_o    <= mem_write_i ? st_be : 4'b1111;
            bus_wdata_o <= mem_write_i ? st_wdata : 32'h0;
            tcnt        <= '0;
            if (misaligned) begin
              state      <= DONE;
              addr_exc_o <= 1'b1;
            end else begin
              state     <= REQ;
              bus_req_o <= 1'b1;
            end
          end
        end
        REQ: begin
          if (bus_ack_i) begin
            state     <= DONE;
            bus_req_o <= 1'b0;
            if (!bus_we_o) begin
              load_data_o  <= ld_ext;
              load_valid_o <= 1'b1;
            end
          end else if (tcnt == TO_LAST) begin
            state       <= DONE;
            bus_req_o   <= 1'b0;
            load_data_o <= 32'h0;
            bus_err_o   <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        // Held instruction is still presented here; returning to IDLE without looking prevents a re-issue.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (TIMEOUT_CYCLES=4); inputs driven and outputs sampled around the falling edge.
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  load_type;
  logic [2:0]  store_type;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        bus_err;
  logic        addr_exc;

  int n_vec = 0;
  int n_err = 0;

  int          r_reqs;
  int          r_stalls;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_addr;
  logic        r_we;
  logic        r_done_stall;
  logic        r_lv;
  logic [31:0] r_ld;
  logic        r_err;
  logic        r_exc;
  logic        r_after_req;
  logic        r_after_lv;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_read_i   (mem_read),
    .mem_write_i  (mem_write),
    .load_type_i  (load_type),
    .store_type_i (store_type),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .bus_req_o    (bus_req),
    .bus_we_o     (bus_we),
    .bus_addr_o   (bus_addr),
    .bus_be_o     (bus_be),
    .bus_wdata_o  (bus_wdata),
    .bus_ack_i    (bus_ack),
    .bus_rdata_i  (bus_rdata),
    .stall_o      (stall),
    .load_data_o  (load_data),
    .load_valid_o (load_valid),
    .bus_err_o    (bus_err),
    .addr_exc_o   (addr_exc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issues one access, acks in REQ cycle ack_at (0 = never), records what the bus and results showed.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] typ,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rdat, input int ack_at);
    @(negedge clk);
    mem_read   = rd;
    mem_write  = wr;
    load_type  = typ;
    store_type = typ;
    addr       = a;
    wdata      = wd;
    bus_rdata  = rdat;
    #1;
    r_stalls = int'(stall);
    r_reqs   = 0;
    r_be     = 4'h0;
    r_wdata  = 32'h0;
    r_addr   = 32'h0;
    r_we     = 1'b0;
    forever begin
      @(negedge clk);
      bus_ack = 1'b0;
      #1;
      if (!bus_req) break;
      r_reqs++;
      r_stalls += int'(stall);
      if (r_reqs == 1) begin
        r_be    = bus_be;
        r_wdata = bus_wdata;
        r_addr  = bus_addr;
        r_we    = bus_we;
      end
      if (r_reqs == ack_at) bus_ack = 1'b1;
      if (r_reqs > 40) begin
        check("req_cycle_bound", 32'(r_reqs), 32'd0);
        break;
      end
    end
    r_done_stall = stall;
    r_lv         = load_valid;
    r_ld         = load_data;
    r_err        = bus_err;
    r_exc        = addr_exc;
    @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    #1;
    r_after_req = bus_req;
    r_after_lv  = load_valid;
  endtask

  initial begin
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; load_type = 3'd0; store_type = 3'd0;
    addr = 32'h0; wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_load_data", load_data, 32'h0);
    check("rst_pulses", {29'd0, load_valid, bus_err, addr_exc}, 32'd0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_be", 32'(bus_be), 32'h0);

    // sb to byte 3, ack in first REQ cycle
    do_access(1'b0, 1'b1, 3'd1, 32'h0000_1003, 32'h0000_00AB, 32'h0, 1);
    check("sb_be", 32'(r_be), 32'h8);
    check("sb_wdata", r_wdata, 32'hABAB_ABAB);
    check("sb_addr", r_addr, 32'h0000_1000);
    check("sb_we", 32'(r_we), 32'd1);
    check("sb_req_cycles", 32'(r_reqs), 32'd1);
    check("sb_stall_cycles", 32'(r_stalls), 32'd2);
    check("sb_done_stall", 32'(r_done_stall), 32'd0);
    check("sb_no_valid", 32'(r_lv), 32'd0);
    check("sb_no_reissue", 32'(r_after_req), 32'd0);

    // lh / lhu upper half, ack after 2 REQ cycles
    do_access(1'b1, 1'b0, 3'd3, 32'h0000_2002, 32'hFFFF_FFFF, 32'h8001_FFFF, 2);
    check("lh_data", r_ld, 32'hFFFF_8001);
    check("lh_valid", 32'(r_lv), 32'd1);
    check("lh_req_cycles", 32'(r_reqs), 32'd2);
    check("lh_rd_be", 32'(r_be), 32'hF);
    check("lh_rd_wdata", r_wdata, 32'h0);
    check("lh_addr", r_addr, 32'h0000_2000);
    check("lh_valid_one_cycle", 32'(r_after_lv), 32'd0);
    do_access(1'b1, 1'b0, 3'd4, 32'h0000_2002, 32'h0, 32'h8001_FFFF, 2);
    check("lhu_data", r_ld, 32'h0000_8001);

    do_access(1'b1, 1'b0, 3'd1, 32'h0000_1001, 32'h0, 32'h1234_F678, 1);
    check("lb_data", r_ld, 32'hFFFF_FFF6);
    do_access(1'b1, 1'b0, 3'd2, 32'h0000_1003, 32'h0, 32'h9A34_5678, 1);
    check("lbu_data", r_ld, 32'h0000_009A);

    do_access(1'b0, 1'b1, 3'd2, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 1);
    check("sh_hi_be", 32'(r_be), 32'hC);
    check("sh_hi_wdata", r_wdata, 32'hBEEF_BEEF);
    do_access(1'b0, 1'b1, 3'd2, 32'h0000_2000, 32'h0000_1234, 32'h0, 1);
    check("sh_lo_be", 32'(r_be), 32'h3);
    do_access(1'b0, 1'b1, 3'd0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1);
    check("sw_be", 32'(r_be), 32'hF);
    check("sw_wdata", r_wdata, 32'hDEAD_BEEF);
    do_access(1'b0, 1'b1, 3'd5, 32'h0000_0014, 32'h1234_5678, 32'h0, 1);
    check("st_type5_be", 32'(r_be), 32'hF);
    check("st_type5_wdata", r_wdata, 32'h1234_5678);
    do_access(1'b1, 1'b0, 3'd7, 32'h0000_0008, 32'h0, 32'hCAFE_F00D, 1);
    check("ld_type7_data", r_ld, 32'hCAFE_F00D);

    // Read and write together must be a write
    do_access(1'b1, 1'b1, 3'd0, 32'h0000_0020, 32'h0000_0055, 32'h1111_1111, 1);
    check("rdwr_we", 32'(r_we), 32'd1);
    check("rdwr_no_valid", 32'(r_lv), 32'd0);

    // Timeout: 4 REQ cycles, error pulse, load data cleared
    do_access(1'b1, 1'b0, 3'd0, 32'h0000_0040, 32'h0, 32'h5555_5555, 0);
    check("to_req_cycles", 32'(r_reqs), 32'd4);
    check("to_err", 32'(r_err), 32'd1);
    check("to_load_data", r_ld, 32'h0);
    check("to_no_valid", 32'(r_lv), 32'd0);
    check("to_back_idle", 32'(r_after_req), 32'd0);

    // Ack on the last timeout cycle wins
    do_access(1'b1, 1'b0, 3'd0, 32'h0000_0044, 32'h0, 32'h0BAD_F00D, 4);
    check("ackto_valid", 32'(r_lv), 32'd1);
    check("ackto_err", 32'(r_err), 32'd0);
    check("ackto_data", r_ld, 32'h0BAD_F00D);

    // Misaligned word load
    do_access(1'b1, 1'b0, 3'd0, 32'h0000_3001, 32'h0, 32'h1122_3344, 1);
`ifdef MEM_ALIGN_CHECK_EN
    check("mis_req_cycles", 32'(r_reqs), 32'd0);
    check("mis_exc", 32'(r_exc), 32'd1);
    check("mis_no_valid", 32'(r_lv), 32'd0);
    check("mis_stall_cycles", 32'(r_stalls), 32'd1);
`else
    check("mis_addr", r_addr, 32'h0000_3000);
    check("mis_valid", 32'(r_lv), 32'd1);
    check("mis_data", r_ld, 32'h1122_3344);
    check("mis_exc", 32'(r_exc), 32'd0);
`endif

    // Reset in the 2nd REQ cycle, then a late ack
    @(negedge clk);
    mem_read = 1'b1; load_type = 3'd0; addr = 32'h0000_4000; bus_rdata = 32'h7777_7777;
    @(negedge clk);
    #1;
    check("rreq_first_req", 32'(bus_req), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    bus_ack = 1'b1;
    #1;
    check("rreq_req_dropped", 32'(bus_req), 32'd0);
    check("rreq_no_valid", 32'(load_valid), 32'd0);
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    check("rreq_late_ack_req", 32'(bus_req), 32'd0);
    check("rreq_late_ack_valid", 32'(load_valid), 32'd0);
    check("rreq_load_data", load_data, 32'h0);
    check("rreq_no_err", 32'(bus_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
